// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART bridge: register offsets,
// STATUS bit positions and the TX sequencer state encoding.
package mmio_uart_pkg;

    // Word offsets from BASE_ADDR
    localparam logic [15:0] OFF_DATA   = 16'd0;
    localparam logic [15:0] OFF_STATUS = 16'd1;

    // STATUS register bit positions
    localparam int unsigned ST_RX_AVAIL = 0;
    localparam int unsigned ST_TX_SPACE = 1;
    localparam int unsigned ST_RX_OVF   = 2;
    localparam int unsigned ST_TX_OVF   = 3;
    localparam int unsigned ST_TX_IDLE  = 4;
    localparam int unsigned ST_RX_CNT_LSB = 8;

    // TX sequencer states
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPulse = 2'd1,
        StWait  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Register-based synchronous FIFO with combinational head, full/empty and
// occupancy count. Full/empty come from the registered count, so a push into
// a full FIFO is dropped even when a pop happens on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [WIDTH-1:0]         o_head
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    assign o_full  = (count_q == CntW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_head  = mem_q[rd_ptr_q];

    assign do_push = i_push & ~o_full;
    assign do_pop  = i_pop & ~o_empty;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge CLK or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array
    always_ff @(posedge CLK or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end
    end

endmodule

// File: rtl/mmio_uart_bridge.sv
// Memory-mapped UART port: DATA/STATUS register pair on the CPU data bus,
// TX and RX byte FIFOs, sticky overflow flags and a TX sequencer that feeds
// the shell's byte-level handshake.
module mmio_uart_bridge
    import mmio_uart_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h4001,
    parameter int unsigned TX_DEPTH  = 16,
    parameter int unsigned RX_DEPTH  = 16
) (
    input  logic        CLK,
    input  logic        i_reset,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    input  logic        i_write,
    input  logic        i_read,
    output logic [15:0] o_rdata,
    output logic        o_hit,
    output logic [7:0]  o_tx_byte,
    output logic        o_tx_valid,
    input  logic        i_tx_sent,
    input  logic [7:0]  i_rx_byte,
    input  logic        i_rx_valid
);

    localparam logic [15:0] AddrData   = BASE_ADDR + OFF_DATA;
    localparam logic [15:0] AddrStatus = BASE_ADDR + OFF_STATUS;

    logic hit_data;
    logic hit_status;

    logic                      tx_push;
    logic                      tx_pop;
    logic                      tx_full;
    logic                      tx_empty;
    logic [$clog2(TX_DEPTH):0] tx_count;
    logic [7:0]                tx_head;

    logic                      rx_pop;
    logic                      rx_full;
    logic                      rx_empty;
    logic [$clog2(RX_DEPTH):0] rx_count;
    logic [7:0]                rx_head;

    logic      rx_ovf_q;
    logic      tx_ovf_q;
    tx_state_e state_q;
    logic      tx_idle;
    logic [15:0] status;
    logic        unused_bits;

    assign hit_data   = (i_addr == AddrData);
    assign hit_status = (i_addr == AddrStatus);
    assign o_hit      = hit_data | hit_status;

    assign tx_push = i_write & hit_data;
    assign rx_pop  = i_read & hit_data;
    // Sequencer drains TX only from IDLE
    assign tx_pop  = (state_q == StIdle) & ~tx_empty;
    assign tx_idle = tx_empty & (state_q == StIdle);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .CLK     (CLK),
        .i_reset (i_reset),
        .i_push  (tx_push),
        .i_wdata (i_wdata[7:0]),
        .i_pop   (tx_pop),
        .o_full  (tx_full),
        .o_empty (tx_empty),
        .o_count (tx_count),
        .o_head  (tx_head)
    );

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .CLK     (CLK),
        .i_reset (i_reset),
        .i_push  (i_rx_valid),
        .i_wdata (i_rx_byte),
        .i_pop   (rx_pop),
        .o_full  (rx_full),
        .o_empty (rx_empty),
        .o_count (rx_count),
        .o_head  (rx_head)
    );

    // Sticky overflow flags; a set in the same cycle as a clear wins
    always_ff @(posedge CLK or posedge i_reset) begin
        if (i_reset) begin
            rx_ovf_q <= 1'b0;
            tx_ovf_q <= 1'b0;
        end else begin
            if (i_rx_valid && rx_full) begin
                rx_ovf_q <= 1'b1;
            end else if (i_write && hit_status && i_wdata[ST_RX_OVF]) begin
                rx_ovf_q <= 1'b0;
            end
            if (tx_push && tx_full) begin
                tx_ovf_q <= 1'b1;
            end else if (i_write && hit_status && i_wdata[ST_TX_OVF]) begin
                tx_ovf_q <= 1'b0;
            end
        end
    end

    // TX sequencer: load a byte, pulse valid for one cycle, wait for sent
    always_ff @(posedge CLK or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= StIdle;
            o_tx_valid <= 1'b0;
            o_tx_byte  <= 8'h00;
        end else begin
            case (state_q)
                StIdle: begin
                    o_tx_valid <= 1'b0;
                    if (!tx_empty) begin
                        o_tx_byte  <= tx_head;
                        o_tx_valid <= 1'b1;
                        state_q    <= StPulse;
                    end
                end
                StPulse: begin
                    o_tx_valid <= 1'b0;
                    state_q    <= i_tx_sent ? StIdle : StWait;
                end
                StWait: begin
                    o_tx_valid <= 1'b0;
                    if (i_tx_sent) state_q <= StIdle;
                end
                default: begin
                    o_tx_valid <= 1'b0;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

    // STATUS register assembly
    always_comb begin
        status                                    = '0;
        status[ST_RX_AVAIL]                       = ~rx_empty;
        status[ST_TX_SPACE]                       = ~tx_full;
        status[ST_RX_OVF]                         = rx_ovf_q;
        status[ST_TX_OVF]                         = tx_ovf_q;
        status[ST_TX_IDLE]                        = tx_idle;
        status[ST_RX_CNT_LSB +: 8]                = 8'(rx_count);
    end

    // Read mux; zero outside the decoded window
    always_comb begin
        o_rdata = 16'h0000;
        if (hit_data) begin
            o_rdata = {8'h00, (rx_empty ? 8'h00 : rx_head)};
        end else if (hit_status) begin
            o_rdata = status;
        end
    end

    assign unused_bits = ^{i_wdata[15:8], tx_count};

endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Scoreboard bench for mmio_uart_bridge: stimulus pushes expected read values
// and TX pulses (byte plus cycle) into queues, a monitor on the falling edge
// pops and compares.
module tb_mmio_uart_bridge;

    localparam logic [15:0] DATA   = 16'h4001;
    localparam logic [15:0] STATUS = 16'h4002;

    logic        CLK = 1'b0;
    logic        i_reset;
    logic [15:0] i_addr;
    logic [15:0] i_wdata;
    logic        i_write;
    logic        i_read;
    logic [15:0] o_rdata;
    logic        o_hit;
    logic [7:0]  o_tx_byte;
    logic        o_tx_valid;
    logic        i_tx_sent;
    logic [7:0]  i_rx_byte;
    logic        i_rx_valid;

    typedef struct {
        string       name;
        logic [16:0] exp;
    } rd_exp_t;

    typedef struct {
        logic [7:0] b;
        int         c;
    } tx_exp_t;

    rd_exp_t rd_q[$];
    tx_exp_t tx_q[$];
    logic    rd_chk = 1'b0;
    int      cyc = 0;
    int      tests = 0;
    int      fails = 0;

    mmio_uart_bridge #(
        .BASE_ADDR (16'h4001),
        .TX_DEPTH  (4),
        .RX_DEPTH  (4)
    ) dut (
        .CLK        (CLK),
        .i_reset    (i_reset),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .i_write    (i_write),
        .i_read     (i_read),
        .o_rdata    (o_rdata),
        .o_hit      (o_hit),
        .o_tx_byte  (o_tx_byte),
        .o_tx_valid (o_tx_valid),
        .i_tx_sent  (i_tx_sent),
        .i_rx_byte  (i_rx_byte),
        .i_rx_valid (i_rx_valid)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: read responses and TX pulses
    always @(negedge CLK) begin
        while (tx_q.size() > 0 && tx_q[0].c < cyc) begin
            tests++;
            fails++;
            $display("FAIL tx_missing: no pulse seen, expected byte %h in cycle %0d",
                     tx_q[0].b, tx_q[0].c);
            void'(tx_q.pop_front());
        end
        if (o_tx_valid) begin
            if (tx_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL tx_unexpected: pulse with byte %h in cycle %0d, none expected",
                         o_tx_byte, cyc);
            end else begin
                tx_exp_t e;
                e = tx_q.pop_front();
                check("tx_byte", {24'h0, o_tx_byte}, {24'h0, e.b});
                check("tx_cycle", cyc, e.c);
            end
        end
        if (rd_chk) begin
            if (rd_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_unexpected: read strobe with empty queue, got %h", o_rdata);
            end else begin
                rd_exp_t r;
                r = rd_q.pop_front();
                check(r.name, {15'h0, o_hit, o_rdata}, {15'h0, r.exp});
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        i_addr  = a;
        i_wdata = d;
        i_write = 1'b1;
        step();
        i_write = 1'b0;
        i_addr  = 16'h0000;
    endtask

    // exp is {o_hit, o_rdata}
    task automatic rd(input logic [15:0] a, input logic [16:0] exp, input string name);
        rd_exp_t r;
        r.name = name;
        r.exp  = exp;
        rd_q.push_back(r);
        i_addr = a;
        rd_chk = 1'b1;
        step();
        rd_chk = 1'b0;
        i_addr = 16'h0000;
    endtask

    task automatic pop_rx();
        i_addr = DATA;
        i_read = 1'b1;
        step();
        i_read = 1'b0;
        i_addr = 16'h0000;
    endtask

    task automatic rx(input logic [7:0] b);
        i_rx_byte  = b;
        i_rx_valid = 1'b1;
        step();
        i_rx_valid = 1'b0;
    endtask

    task automatic sent();
        i_tx_sent = 1'b1;
        step();
        i_tx_sent = 1'b0;
    endtask

    task automatic expect_tx(input logic [7:0] b, input int c);
        tx_exp_t e;
        e.b = b;
        e.c = c;
        tx_q.push_back(e);
    endtask

    initial begin
        int c;
        i_reset = 1'b1;
        i_addr = 16'h0000; i_wdata = 16'h0000; i_write = 1'b0; i_read = 1'b0;
        i_tx_sent = 1'b0; i_rx_byte = 8'h00; i_rx_valid = 1'b0;

        // Reset state
        step();
        rd(STATUS, 17'h1_0012, "reset_status");
        check("reset_tx_valid", {31'h0, o_tx_valid}, 32'h0);
        check("reset_tx_byte", {24'h0, o_tx_byte}, 32'h0);
        step();
        i_reset = 1'b0;
        step();
        step();

        // Single TX
        c = cyc;
        wr(DATA, 16'h0041);
        expect_tx(8'h41, c + 2);
        wait_until(c + 5);
        rd(STATUS, 17'h1_0002, "tx_busy_status");
        wait_until(c + 10);
        sent();
        wait_until(c + 12);
        rd(STATUS, 17'h1_0012, "tx_idle_status");

        // TX overflow: 0x01 goes in flight, 0x02..0x05 stored, 0x06 dropped
        step();
        c = cyc;
        expect_tx(8'h01, c + 2);
        for (int i = 1; i <= 6; i++) wr(DATA, 16'(i));
        rd(STATUS, 17'h1_0008, "tx_ovf_status");
        wr(STATUS, 16'h0008);
        rd(STATUS, 17'h1_0000, "tx_ovf_clear");
        for (int b = 2; b <= 5; b++) begin
            c = cyc;
            expect_tx(8'(b), c + 2);
            sent();
            step();
            step();
        end
        sent();
        step();
        rd(STATUS, 17'h1_0012, "tx_drained_status");

        // RX path while a TX byte is in flight
        c = cyc;
        wr(DATA, 16'h0007);
        expect_tx(8'h07, c + 2);
        rx(8'h55);
        rx(8'hAA);
        rd(STATUS, 17'h1_0203, "rx_two_status");
        rd(DATA, 17'h1_0055, "rx_head_55");
        pop_rx();
        rd(DATA, 17'h1_00AA, "rx_head_aa");
        rd(STATUS, 17'h1_0103, "rx_one_status");
        pop_rx();
        pop_rx();
        rd(DATA, 17'h1_0000, "rx_empty_data");
        rd(STATUS, 17'h1_0002, "rx_empty_status");
        sent();
        step();
        rd(STATUS, 17'h1_0012, "rx_tx_idle_status");

        // RX overflow with simultaneous pop
        for (int b = 16; b < 20; b++) rx(8'(b));
        rd(STATUS, 17'h1_0413, "rx_full_status");
        i_rx_byte = 8'h99; i_rx_valid = 1'b1; i_addr = DATA; i_read = 1'b1;
        step();
        i_rx_valid = 1'b0; i_read = 1'b0; i_addr = 16'h0000;
        rd(STATUS, 17'h1_0317, "rx_ovf_pop_status");
        rd(DATA, 17'h1_0011, "rx_ovf_head");
        rx(8'h14);
        // Overflow and clear in the same cycle: set wins
        i_rx_byte = 8'h98; i_rx_valid = 1'b1;
        i_addr = STATUS; i_wdata = 16'h0004; i_write = 1'b1;
        step();
        i_rx_valid = 1'b0; i_write = 1'b0; i_addr = 16'h0000;
        rd(STATUS, 17'h1_0417, "rx_ovf_set_wins");
        wr(STATUS, 16'h0004);
        rd(STATUS, 17'h1_0413, "rx_ovf_clear");
        for (int b = 17; b <= 20; b++) begin
            rd(DATA, {9'h100, 8'(b)}, "rx_drain");
            pop_rx();
        end
        rd(STATUS, 17'h1_0012, "rx_drained_status");

        // Decode boundaries
        rd(16'h4003, 17'h0_0000, "decode_4003");
        wr(16'h4000, 16'h0041);
        wr(16'h4003, 16'h0042);
        wr(16'h4000, 16'h000C);
        rx(8'h66);
        rd(16'h4000, 17'h0_0000, "decode_4000");
        i_addr = 16'h4003; i_read = 1'b1;
        step();
        i_read = 1'b0; i_addr = 16'h0000;
        rd(DATA, 17'h1_0066, "decode_no_pop");
        rd(STATUS, 17'h1_0113, "decode_status");
        pop_rx();
        step();

        // Reset mid-send
        c = cyc;
        expect_tx(8'hA1, c + 2);
        wr(DATA, 16'h00A1);
        wr(DATA, 16'h00B2);
        wr(DATA, 16'h00C3);
        wait_until(c + 5);
        i_reset = 1'b1;
        #1;
        check("async_reset_tx_byte", {24'h0, o_tx_byte}, 32'h0);
        check("async_reset_tx_valid", {31'h0, o_tx_valid}, 32'h0);
        step();
        step();
        i_reset = 1'b0;
        step();
        rd(STATUS, 17'h1_0012, "post_reset_status");
        sent();
        for (int i = 0; i < 5; i++) step();
        rd(STATUS, 17'h1_0012, "stray_sent_status");
        step();

        check("tx_queue_drained", tx_q.size(), 32'h0);
        check("rd_queue_drained", rd_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mmio_uart_bridge.md
# mmio_uart_bridge

Memory-mapped UART port for the Hack system: decodes two words starting at `BASE_ADDR` on the CPU data-memory bus and buffers transmit and receive bytes in parametrised FIFOs. The CPU gets a readable status register and sticky overflow flags. The block connects to the shell's byte-level UART handshake (`o_UART_byte`/`o_UART_byte_ready`/`i_UART_byte_sent` side). It supersedes the single-register, write-only UART mapping at 0x4001 by adding RX buffering, status readback and back-pressure.

## Interface
- `BASE_ADDR`, 16'h4001, word address of the DATA register; STATUS is at `BASE_ADDR+1`.
- `TX_DEPTH`, 16, TX FIFO entries; power of two, 2..128.
- `RX_DEPTH`, 16, RX FIFO entries; power of two, 2..128.
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `i_reset`  in  1  reset, asynchronous, active-high.
- `i_addr`  in  16  CPU data address.
- `i_wdata`  in  16  CPU write data.
- `i_write`  in  1  CPU write strobe; one write per cycle high.
- `i_read`  in  1  CPU read-consume strobe; one pop per cycle high when addressing DATA.
- `o_rdata`  out  16  combinational read data; 16'h0000 when `o_hit`=0.
- `o_hit`  out  1  combinational; `i_addr` equals DATA or STATUS. The system uses it to suppress the RAM write.
- `o_tx_byte`  out  8  byte offered to the shell.
- `o_tx_valid`  out  1  one-cycle pulse: `o_tx_byte` is valid and must be sent.
- `i_tx_sent`  in  1  pulse from the shell: the last offered byte has finished.
- `i_rx_byte`  in  8  received byte.
- `i_rx_valid`  in  1  one-cycle pulse: `i_rx_byte` is valid.

## Operation
- **DATA write:** pushes `i_wdata[7:0]` into the TX FIFO. If the FIFO is full, the byte is dropped and `tx_ovf` is set.
- **DATA read:** `o_rdata` = {8'h00, RX head}, or 16'h0000 if RX is empty. `i_read` with DATA addressed pops RX; a pop when empty is a no-op.
- **STATUS read:** returns the following fields.
  - bit0 `rx_avail` (RX not empty)
  - bit1 `tx_space` (TX not full)
  - bit2 `rx_ovf`
  - bit3 `tx_ovf`
  - bit4 `tx_idle` (TX empty and FSM in IDLE)
  - bits[15:8] RX count, zero-extended
  - other bits 0
- **STATUS write:** writing 1 to bit2 or bit3 clears that flag; all other bits are ignored.
- **RX push:** `i_rx_valid` pushes `i_rx_byte`. If RX is full, the byte is dropped and `rx_ovf` is set.
- **Full/empty evaluation:** computed from the pre-edge count. A push to a full FIFO is dropped even if a pop happens in the same cycle; it still counts as an overflow. A push and pop on a non-full, non-empty FIFO are both performed and the count is unchanged.
- **Flag priority:** if an overflow and a clear of the same flag happen in the same cycle, set wins.
- **TX FSM:**
  - IDLE: if TX is not empty, pop and load `o_tx_byte`; go to PULSE.
  - PULSE: `o_tx_valid`=1. If `i_tx_sent` is high, go to IDLE; otherwise go to WAIT.
  - WAIT: on `i_tx_sent`, go to IDLE.
  - `i_tx_sent` in IDLE is ignored.
  - `o_tx_byte` holds its value until the next load.
- **Count width:** clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.

## Timing
- **Reset values:**
  - FIFOs empty; flags 0.
  - FSM IDLE.
  - `o_tx_valid`=0, `o_tx_byte`=8'h00.
  - `o_rdata`/`o_hit` follow `i_addr` combinationally.
- **TX latency:**
  - Write accepted at the edge ending cycle c.
  - FSM pops at the edge ending c+1.
  - `o_tx_valid` is high during c+2 only.
- **Back-to-back TX:** `i_tx_sent` in cycle k (FSM in WAIT or PULSE) puts the FSM in IDLE in k+1. The next `o_tx_valid` is in k+2 if data is pending.
- **Visibility:** STATUS and DATA reads reflect writes and pushes from the next cycle onward; there is no same-cycle bypass.
- **Reset mid-operation:** `i_reset` asserted at any time clears everything asynchronously. A byte in flight is abandoned, and a later stray `i_tx_sent` is ignored.

## Structure
- **Package `mmio_uart_pkg`:**
  - register offsets (`OFF_DATA`=0, `OFF_STATUS`=1)
  - STATUS bit indices
  - TX FSM state enum (IDLE, PULSE, WAIT)
- **Sub-module `sync_fifo`:** parameters WIDTH, DEPTH; push/pop, full/empty/count, head output. Instantiated twice (TX and RX). Register-based, same clock and asynchronous reset.
- **Top level:** address decode, read mux, flag registers and the TX FSM.

## Test plan
- **Single TX:** reset, write 0x0041 to 0x4001 in cycle 10 → `o_tx_valid` high exactly in cycle 12 with `o_tx_byte`=0x41. `i_tx_sent` in cycle 20 → STATUS bit4=1 readable from cycle 22.
- **TX overflow:** TX_DEPTH=4, `i_tx_sent` held low, 6 writes 0x01..0x06 → one byte is in flight. FIFO holds 0x02..0x05, 0x06 is dropped, STATUS bit3=1 and bit1=0. Write 0x0008 to 0x4002 → bit3=0.
- **RX path:** push 0x55, 0xAA → STATUS = 0x0203. DATA reads 0x0055; `i_read` → DATA 0x00AA, count 1. `i_read` twice → DATA 0x0000, count 0, bit0=0.
- **RX overflow and simultaneity:** fill RX_DEPTH=4, then `i_rx_valid` with `i_read` in the same cycle → pop occurs, byte dropped, `rx_ovf`=1, count 3.
- **Decode:** `i_addr`=0x4003 or 0x4000 → `o_hit`=0, `o_rdata`=0, writes have no effect.
- **Reset mid-send:** assert `i_reset` during WAIT with 3 bytes queued → `o_tx_valid` stays 0. STATUS reads 0x0012 after release, and a later `i_tx_sent` causes no pulse.
